debug_run_control: RTL

- Run-control sequencer for the 3-stage RV32I core under the external debugger.
- Halts the pipeline on debugger request, on ebreak, or after a single step. It stops fetch, drains in-flight instructions and captures the debug PC (dpc) and cause.
- On resume it reloads the PC and restarts fetch.
- Sits between the debug module interface and the fetch stage. It consumes the stage-3 instruction-complete indication.

---
 rtl/debug_run_control.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/debug_run_control.sv
`default_nettype none
// ============================================================================
// Module   : debug_run_control
// Brief    : Halt/drain/resume/step sequencer between the debug module and fetch.
// Revision : 1.0
// ============================================================================
module debug_run_control #(
  parameter int MAX_INFLIGHT  = 3,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_haltreq,
  input  logic        dbg_resumereq,
  input  logic        dbg_step_en,
  input  logic        issue_valid,
  input  logic        retire_valid,
  input  logic [31:0] retire_next_pc,
  input  logic [1:0]  kill_cnt,
  input  logic        ebreak_retire,
  input  logic [31:0] ebreak_pc,
  input  logic [31:0] fetch_pc,
  output logic        fetch_hold,
  output logic        flush_req,
  output logic        pc_load,
  output logic [31:0] pc_load_val,
  output logic        halted,
  output logic        running,
  output logic        resumeack,
  output logic [31:0] dpc,
  output logic [2:0]  dcause,
  output logic        drain_err
);

  localparam int c_cnt_w = $clog2(MAX_INFLIGHT + 1);
  localparam int c_sum_w = c_cnt_w + 3;
  localparam int c_tmo_w = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [2:0] c_st_run    = 3'd0;
  localparam logic [2:0] c_st_drain  = 3'd1;
  localparam logic [2:0] c_st_halted = 3'd2;
  localparam logic [2:0] c_st_resume = 3'd3;
  localparam logic [2:0] c_st_step   = 3'd4;

  localparam logic [2:0] c_cause_ebreak  = 3'd1;
  localparam logic [2:0] c_cause_haltreq = 3'd3;
  localparam logic [2:0] c_cause_step    = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] w_inflight_next;
  logic [c_sum_w-1:0] w_sum;
  logic               w_cnt_err;
  logic [c_tmo_w-1:0] r_timeout;
  logic [31:0]        r_dpc;
  logic [2:0]         r_dcause;
  logic               r_drain_err;
  logic               r_ebreak_drain;
  logic               r_step_pending;
  logic               r_halted;
  logic               r_running;
  logic               w_retire;
  logic               w_drain_done;
  logic               w_timeout_hit;
  logic               w_timeout_force;

  assign w_retire = retire_valid | ebreak_retire;

  // Sign bit of the widened sum flags underflow; magnitude beyond MAX flags overflow.
  assign w_sum = c_sum_w'(r_inflight) + c_sum_w'(issue_valid)
               - c_sum_w'(w_retire) - c_sum_w'(kill_cnt);

  always_comb begin
    w_inflight_next = w_sum[c_cnt_w-1:0];
    w_cnt_err       = 1'b0;
    if (w_sum[c_sum_w-1]) begin
      w_inflight_next = '0;
      w_cnt_err       = 1'b1;
    end else if (w_sum > c_sum_w'(MAX_INFLIGHT)) begin
      w_inflight_next = c_cnt_w'(MAX_INFLIGHT);
      w_cnt_err       = 1'b1;
    end
  end

  assign w_drain_done    = (r_inflight == '0) && !w_retire && (kill_cnt == 2'd0) && !issue_valid;
  assign w_timeout_hit   = (r_timeout == c_tmo_w'(DRAIN_TIMEOUT - 1));
  assign w_timeout_force = (r_state == c_st_drain) && w_timeout_hit && !w_drain_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_run:    if (ebreak_retire || dbg_haltreq) w_next_state = c_st_drain;
      c_st_drain:  if (w_drain_done || w_timeout_hit) w_next_state = c_st_halted;
      c_st_halted: if (dbg_resumereq) w_next_state = c_st_resume;
      c_st_resume: w_next_state = r_step_pending ? c_st_step : c_st_run;
      c_st_step:   if (ebreak_retire || issue_valid) w_next_state = c_st_drain;
      default:     w_next_state = c_st_run;
    endcase
  end

  always_comb begin
    fetch_hold = 1'b0;
    flush_req  = 1'b0;
    pc_load    = 1'b0;
    resumeack  = 1'b0;
    case (r_state)
      c_st_run:    flush_req = ebreak_retire;
      c_st_drain:  fetch_hold = 1'b1;
      c_st_halted: fetch_hold = 1'b1;
      c_st_resume: begin
        fetch_hold = 1'b1;
        pc_load    = 1'b1;
        resumeack  = 1'b1;
      end
      c_st_step:   flush_req = ebreak_retire;
      default:     fetch_hold = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight     <= '0;
      r_timeout      <= '0;
      r_dpc          <= '0;
      r_dcause       <= '0;
      r_drain_err    <= 1'b0;
      r_ebreak_drain <= 1'b0;
      r_step_pending <= 1'b0;
      r_halted       <= 1'b0;
      r_running      <= 1'b1;
    end else begin
      r_halted  <= (w_next_state == c_st_halted);
      r_running <= (w_next_state != c_st_halted);
      r_inflight <= w_timeout_force ? '0 : w_inflight_next;
      if (w_cnt_err || w_timeout_force) begin
        r_drain_err <= 1'b1;
      end
      r_timeout <= (r_state == c_st_drain) ? r_timeout + c_tmo_w'(1) : '0;

      case (r_state)
        c_st_run: begin
          if (ebreak_retire) begin
            r_dpc          <= ebreak_pc;
            r_dcause       <= c_cause_ebreak;
            r_ebreak_drain <= 1'b1;
          end else if (dbg_haltreq) begin
            r_dpc          <= fetch_pc;
            r_dcause       <= c_cause_haltreq;
            r_ebreak_drain <= 1'b0;
          end
        end
        // An ebreak-initiated drain must keep the ebreak PC as dpc.
        c_st_drain: begin
          if (retire_valid && !r_ebreak_drain) begin
            r_dpc <= retire_next_pc;
          end
        end
        c_st_halted: begin
          if (dbg_resumereq) begin
            r_step_pending <= dbg_step_en;
          end
        end
        c_st_step: begin
          if (ebreak_retire) begin
            r_dpc          <= ebreak_pc;
            r_dcause       <= c_cause_ebreak;
            r_ebreak_drain <= 1'b1;
          end else if (issue_valid) begin
            r_dcause       <= c_cause_step;
            r_ebreak_drain <= 1'b0;
          end
        end
        default: begin
          r_ebreak_drain <= r_ebreak_drain;
        end
      endcase
    end
  end

  assign halted      = r_halted;
  assign running     = r_running;
  assign dpc         = r_dpc;
  assign dcause      = r_dcause;
  assign drain_err   = r_drain_err;
  assign pc_load_val = r_dpc;

endmodule
`default_nettype wire
